// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcode/function encodings,
// decoded operation, FSM states and flag bit positions. Optional macro: ALU_DIV_EN.
package alu_pkg;

    localparam logic [5:0] OP_R_TYPE = 6'h00;
    localparam logic [5:0] OP_BEQZ   = 6'h04;
    localparam logic [5:0] OP_BNEZ   = 6'h05;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_SUBI   = 6'h09;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;

    localparam logic [5:0] FN_SLL    = 6'h00;
    localparam logic [5:0] FN_SRL    = 6'h02;
    localparam logic [5:0] FN_SRA    = 6'h03;
    localparam logic [5:0] FN_MULT   = 6'h18;
    localparam logic [5:0] FN_DIV    = 6'h1A;
    localparam logic [5:0] FN_ADD    = 6'h20;
    localparam logic [5:0] FN_SUB    = 6'h22;
    localparam logic [5:0] FN_AND    = 6'h24;
    localparam logic [5:0] FN_OR     = 6'h25;
    localparam logic [5:0] FN_XOR    = 6'h26;
    localparam logic [5:0] FN_NOT    = 6'h27;
    localparam logic [5:0] FN_SLT    = 6'h2A;
    localparam logic [5:0] FN_CMP    = 6'h2B;

    localparam int unsigned FLAG_ZERO  = 3;
    localparam int unsigned FLAG_NEG   = 2;
    localparam int unsigned FLAG_CARRY = 1;
    localparam int unsigned FLAG_OVF   = 0;

    // Branch ops only drive the branch decision; their data result is 0.
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOT,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_MUL, ALU_DIV,
        ALU_BEQZ, ALU_BNEZ, ALU_NOP
    } alu_op_e;

    typedef enum logic { MODE_MUL, MODE_DIV } md_mode_e;

`ifdef ALU_DIV_EN
    typedef enum logic [1:0] { ST_IDLE, ST_MUL, ST_DIV } alu_state_e;
`else
    typedef enum logic { ST_IDLE, ST_MUL } alu_state_e;
`endif

endpackage

// File: rtl/alu_mc_if.sv
// Operand/result handshake bundle between the execute stage and alu_mc.
interface alu_mc_if #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned OPCODE_WIDTH   = 6,
    parameter int unsigned FUNCTION_WIDTH = 6
);
    logic                      alu_in_valid;
    logic                      alu_in_ready;
    logic [DATA_WIDTH-1:0]     alu_data_in_a;
    logic [DATA_WIDTH-1:0]     alu_data_in_b;
    logic [OPCODE_WIDTH-1:0]   alu_opcode;
    logic [FUNCTION_WIDTH-1:0] alu_function;
    logic                      alu_out_valid;
    logic                      alu_out_ready;
    logic [DATA_WIDTH-1:0]     alu_data_out;
    logic                      alu_branch_result;
    logic [3:0]                alu_flags;
    logic                      alu_div_by_zero;

    modport master (
        output alu_in_valid, alu_data_in_a, alu_data_in_b, alu_opcode, alu_function,
        output alu_out_ready,
        input  alu_in_ready, alu_out_valid, alu_data_out, alu_branch_result,
        input  alu_flags, alu_div_by_zero
    );

    modport slave (
        input  alu_in_valid, alu_data_in_a, alu_data_in_b, alu_opcode, alu_function,
        input  alu_out_ready,
        output alu_in_ready, alu_out_valid, alu_data_out, alu_branch_result,
        output alu_flags, alu_div_by_zero
    );
endinterface

// File: rtl/alu_iter_muldiv.sv
// Iterative shift-add multiplier / restoring divider sharing one register set;
// one step per cycle, DATA_WIDTH steps. Divider present only with ALU_DIV_EN.
module alu_iter_muldiv
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  md_mode_e              mode,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  div_by_zero
);
    localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

    logic [CW-1:0]         count;
    logic [DATA_WIDTH-1:0] acc, sreg, oreg;
    logic [DATA_WIDTH-1:0] acc_nx, sreg_nx, oreg_nx;
    logic                  go;

`ifdef ALU_DIV_EN
    md_mode_e              mode_q;
    logic                  dbz_q;
    logic [DATA_WIDTH:0]   shifted;

    assign go = start;
`else
    assign go = start && (mode == MODE_MUL);
`endif

    // MUL: acc accumulates, sreg = multiplier (shifts right), oreg = multiplicand (shifts left).
    // DIV: acc = partial remainder, sreg = dividend becoming quotient, oreg = divisor.
    always_comb begin
        acc_nx  = acc;
        sreg_nx = sreg >> 1;
        oreg_nx = oreg << 1;
        if (sreg[0]) acc_nx = acc + oreg;
`ifdef ALU_DIV_EN
        shifted = {acc, sreg[DATA_WIDTH-1]};
        if (mode_q == MODE_DIV) begin
            oreg_nx = oreg;
            if (shifted >= {1'b0, oreg}) begin
                acc_nx  = DATA_WIDTH'(shifted - {1'b0, oreg});
                sreg_nx = {sreg[DATA_WIDTH-2:0], 1'b1};
            end else begin
                acc_nx  = shifted[DATA_WIDTH-1:0];
                sreg_nx = {sreg[DATA_WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            acc   <= '0;
            sreg  <= '0;
            oreg  <= '0;
`ifdef ALU_DIV_EN
            mode_q <= MODE_MUL;
            dbz_q  <= 1'b0;
`endif
        end else if (go) begin
            count <= CW'(DATA_WIDTH);
            acc   <= '0;
            sreg  <= op_a;
            oreg  <= op_b;
`ifdef ALU_DIV_EN
            mode_q <= mode;
            dbz_q  <= (mode == MODE_DIV) && (op_b == '0);
`endif
        end else if (count != '0) begin
            count <= count - CW'(1);
            acc   <= acc_nx;
            sreg  <= sreg_nx;
            oreg  <= oreg_nx;
        end
    end

    assign done = (count == CW'(1));

`ifdef ALU_DIV_EN
    assign result      = (mode_q == MODE_DIV) ? sreg_nx : acc_nx;
    assign div_by_zero = dbz_q;
`else
    assign result      = acc_nx;
    assign div_by_zero = 1'b0;
`endif

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU: decode, single-cycle datapath, handshake and
// registered outputs; MULT/DIV delegated to alu_iter_muldiv. Optional macro: ALU_DIV_EN.
module alu_mc
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned OPCODE_WIDTH   = 6,
    parameter int unsigned FUNCTION_WIDTH = 6
) (
    input logic      clk,
    input logic      rst,
    alu_mc_if.slave  bus
);
    localparam int unsigned MSB  = DATA_WIDTH - 1;
    localparam int unsigned SH_W = $clog2(DATA_WIDTH);

    alu_state_e            state_q, state_d;
    alu_op_e               op;
    md_mode_e              md_mode;
    logic                  accept, md_start, md_done, md_dbz;
    logic                  load_single, load_md;
    logic [DATA_WIDTH-1:0] a, b, sc_result, md_result, sel_result;
    logic [DATA_WIDTH:0]   sum, diff;
    logic [SH_W-1:0]       shamt;
    logic                  sc_carry, sc_ovf, sc_branch;
    logic [3:0]            flags_d;

    logic                  out_valid_q, branch_q, dbz_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [3:0]            flags_q;

    assign a = bus.alu_data_in_a;
    assign b = bus.alu_data_in_b;

    assign bus.alu_in_ready = (state_q == ST_IDLE) && (!out_valid_q || bus.alu_out_ready);
    assign accept           = bus.alu_in_valid && bus.alu_in_ready;

    always_comb begin
        op = ALU_NOP;
        if (bus.alu_opcode == OPCODE_WIDTH'(OP_R_TYPE)) begin
            case (bus.alu_function)
                FUNCTION_WIDTH'(FN_ADD):  op = ALU_ADD;
                FUNCTION_WIDTH'(FN_SUB):  op = ALU_SUB;
                FUNCTION_WIDTH'(FN_CMP):  op = ALU_SUB;
                FUNCTION_WIDTH'(FN_AND):  op = ALU_AND;
                FUNCTION_WIDTH'(FN_OR):   op = ALU_OR;
                FUNCTION_WIDTH'(FN_XOR):  op = ALU_XOR;
                FUNCTION_WIDTH'(FN_NOT):  op = ALU_NOT;
                FUNCTION_WIDTH'(FN_SLL):  op = ALU_SLL;
                FUNCTION_WIDTH'(FN_SRL):  op = ALU_SRL;
                FUNCTION_WIDTH'(FN_SRA):  op = ALU_SRA;
                FUNCTION_WIDTH'(FN_SLT):  op = ALU_SLT;
                FUNCTION_WIDTH'(FN_MULT): op = ALU_MUL;
                FUNCTION_WIDTH'(FN_DIV):  op = ALU_DIV;
                default:                  op = ALU_NOP;
            endcase
        end else begin
            case (bus.alu_opcode)
                OPCODE_WIDTH'(OP_ADDI): op = ALU_ADD;
                OPCODE_WIDTH'(OP_SUBI): op = ALU_SUB;
                OPCODE_WIDTH'(OP_ANDI): op = ALU_AND;
                OPCODE_WIDTH'(OP_ORI):  op = ALU_OR;
                OPCODE_WIDTH'(OP_BEQZ): op = ALU_BEQZ;
                OPCODE_WIDTH'(OP_BNEZ): op = ALU_BNEZ;
                default:                op = ALU_NOP;
            endcase
        end
    end

    // Carry for subtraction is the borrow out of the zero-extended difference.
    always_comb begin
        sum       = {1'b0, a} + {1'b0, b};
        diff      = {1'b0, a} - {1'b0, b};
        shamt     = b[SH_W-1:0];
        sc_result = '0;
        sc_carry  = 1'b0;
        sc_ovf    = 1'b0;
        sc_branch = 1'b0;
        case (op)
            ALU_ADD: begin
                sc_result = sum[MSB:0];
                sc_carry  = sum[DATA_WIDTH];
                sc_ovf    = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            ALU_SUB: begin
                sc_result = diff[MSB:0];
                sc_carry  = diff[DATA_WIDTH];
                sc_ovf    = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            end
            ALU_AND:  sc_result = a & b;
            ALU_OR:   sc_result = a | b;
            ALU_XOR:  sc_result = a ^ b;
            ALU_NOT:  sc_result = ~b;
            ALU_SLL:  sc_result = a << shamt;
            ALU_SRL:  sc_result = a >> shamt;
            ALU_SRA:  sc_result = $signed(a) >>> shamt;
            ALU_SLT:  sc_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_BEQZ: sc_branch = (a == '0);
            ALU_BNEZ: sc_branch = (a != '0);
            default: ;
        endcase
    end

`ifdef ALU_DIV_EN
    assign md_start = accept && ((op == ALU_MUL) || (op == ALU_DIV));
`else
    assign md_start = accept && (op == ALU_MUL);
`endif
    assign md_mode = (op == ALU_DIV) ? MODE_DIV : MODE_MUL;

    alu_iter_muldiv #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_muldiv (
        .clk         (clk),
        .rst         (rst),
        .start       (md_start),
        .mode        (md_mode),
        .op_a        (a),
        .op_b        (b),
        .done        (md_done),
        .result      (md_result),
        .div_by_zero (md_dbz)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (md_start) begin
`ifdef ALU_DIV_EN
                    state_d = (md_mode == MODE_DIV) ? ST_DIV : ST_MUL;
`else
                    state_d = ST_MUL;
`endif
                end
            end
            ST_MUL: if (md_done) state_d = ST_IDLE;
`ifdef ALU_DIV_EN
            ST_DIV: if (md_done) state_d = ST_IDLE;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    assign load_single = accept && !md_start;
    assign load_md     = md_done;
    assign sel_result  = load_md ? md_result : sc_result;

    always_comb begin
        flags_d             = '0;
        flags_d[FLAG_ZERO]  = (sel_result == '0);
        flags_d[FLAG_NEG]   = sel_result[MSB];
        flags_d[FLAG_CARRY] = !load_md && sc_carry;
        flags_d[FLAG_OVF]   = !load_md && sc_ovf;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            data_q      <= '0;
            flags_q     <= '0;
            branch_q    <= 1'b0;
            dbz_q       <= 1'b0;
        end else if (load_single || load_md) begin
            out_valid_q <= 1'b1;
            data_q      <= sel_result;
            flags_q     <= flags_d;
            branch_q    <= !load_md && sc_branch;
            dbz_q       <= load_md && md_dbz;
        end else if (bus.alu_out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.alu_out_valid     = out_valid_q;
    assign bus.alu_data_out      = data_q;
    assign bus.alu_flags         = flags_q;
    assign bus.alu_branch_result = branch_q;
    assign bus.alu_div_by_zero   = dbz_q;

endmodule
